// File: rtl/sample_packer_if.sv
// Sample stream in, packed-word stream out, plus flush/overflow control.
// The slave modport is the packer; the master modport is its environment.
interface sample_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_NUM   = 4
);
    logic                             din_vld;
    logic [DATA_WIDTH-1:0]            din;
    logic                             flush;
    logic                             clr_ovf;
    logic                             dout_vld;
    logic                             dout_rdy;
    logic [PACK_NUM*DATA_WIDTH-1:0]   dout;
    logic [3:0]                       dout_cnt;
    logic                             ovf;

    modport slave (
        input  din_vld, din, flush, clr_ovf, dout_rdy,
        output dout_vld, dout, dout_cnt, ovf
    );

    modport master (
        output din_vld, din, flush, clr_ovf, dout_rdy,
        input  dout_vld, dout, dout_cnt, ovf
    );
endinterface

// File: rtl/sample_packer.sv
// Packs PACK_NUM consecutive samples into one word (lane 0 = first sample)
// and queues finished words in a 2-entry output FIFO with valid/ready.
// The FIFO is a head/tail shift pair so every output is a plain register.
module sample_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_NUM   = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    sample_packer_if.slave     bus
);
    localparam int WORD_W = PACK_NUM * DATA_WIDTH;

    logic [3:0]        lane_cnt_q, lane_cnt_d;
    logic [WORD_W-1:0] lanes_q, lanes_d;
    logic [WORD_W-1:0] head_data_q, head_data_d;
    logic [3:0]        head_cnt_q, head_cnt_d;
    logic [WORD_W-1:0] tail_data_q, tail_data_d;
    logic [3:0]        tail_cnt_q, tail_cnt_d;
    logic [1:0]        occ_q, occ_d;
    logic              dout_vld_q, dout_vld_d;
    logic              ovf_q, ovf_d;

    logic [WORD_W-1:0] word_s;
    logic [3:0]        fill_cnt_s;
    logic              full_s;
    logic              push_s;
    logic              pop_s;
    logic              push_ok_s;
    logic              drop_s;

    // Word assembly: merge the incoming sample into its lane and decide on a push.
    always_comb begin
        word_s = lanes_q;
        for (int k = 0; k < PACK_NUM; k++) begin
            if (bus.din_vld && (lane_cnt_q == 4'(k))) begin
                word_s[k*DATA_WIDTH +: DATA_WIDTH] = bus.din;
            end else begin
                word_s[k*DATA_WIDTH +: DATA_WIDTH] = lanes_q[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        fill_cnt_s = lane_cnt_q + {3'b000, bus.din_vld};
        full_s     = bus.din_vld && (lane_cnt_q == 4'(PACK_NUM - 1));
        // A flush that lands on a word just completed by this sample adds nothing extra.
        push_s     = full_s || (bus.flush && (fill_cnt_s != 4'd0));
        pop_s      = dout_vld_q && bus.dout_rdy;
        push_ok_s  = push_s && ((occ_q != 2'd2) || pop_s);
        drop_s     = push_s && !push_ok_s;
        // Counter and lanes restart after any push, dropped or not, to keep alignment.
        if (push_s) begin
            lane_cnt_d = 4'd0;
            lanes_d    = '0;
        end else begin
            lane_cnt_d = fill_cnt_s;
            lanes_d    = word_s;
        end
    end

    // Output FIFO next state: head is what the consumer sees, tail is the spare slot.
    always_comb begin
        head_data_d = head_data_q;
        head_cnt_d  = head_cnt_q;
        tail_data_d = tail_data_q;
        tail_cnt_d  = tail_cnt_q;
        occ_d       = occ_q;
        case ({push_ok_s, pop_s})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_data_d = word_s;
                    head_cnt_d  = fill_cnt_s;
                end else begin
                    tail_data_d = word_s;
                    tail_cnt_d  = fill_cnt_s;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_data_d = tail_data_q;
                head_cnt_d  = tail_cnt_q;
                tail_data_d = '0;
                tail_cnt_d  = 4'd0;
                occ_d       = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_data_d = word_s;
                    head_cnt_d  = fill_cnt_s;
                end else begin
                    head_data_d = tail_data_q;
                    head_cnt_d  = tail_cnt_q;
                    tail_data_d = word_s;
                    tail_cnt_d  = fill_cnt_s;
                end
            end
            default: begin
                occ_d = occ_q;
            end
        endcase
        dout_vld_d = (occ_d != 2'd0);
        // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers with asynchronous clear of all lanes, FIFO entries and flags.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lane_cnt_q  <= 4'd0;
            lanes_q     <= '0;
            head_data_q <= '0;
            head_cnt_q  <= 4'd0;
            tail_data_q <= '0;
            tail_cnt_q  <= 4'd0;
            occ_q       <= 2'd0;
            dout_vld_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            lane_cnt_q  <= lane_cnt_d;
            lanes_q     <= lanes_d;
            head_data_q <= head_data_d;
            head_cnt_q  <= head_cnt_d;
            tail_data_q <= tail_data_d;
            tail_cnt_q  <= tail_cnt_d;
            occ_q       <= occ_d;
            dout_vld_q  <= dout_vld_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.dout_vld = dout_vld_q;
    assign bus.dout     = head_data_q;
    assign bus.dout_cnt = head_cnt_q;
    assign bus.ovf      = ovf_q;
endmodule
